word_unload_257: RTL and testbench

WORD_UNLOAD_257 -- requirements
Module: word_unload_257

---
 rtl/word_unload_257_pkg.sv | 11 +
 rtl/word_mux_16.sv | 20 ++
 rtl/word_unload_257.sv | 92 +++++++++
 tb/tb_word_unload_257.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_unload_257_pkg.sv
// Shared types and constants for the word-serial unload block.
package word_unload_257_pkg;
  localparam int WORD_W    = 16;
  localparam int NWORD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;
endpackage

// File: rtl/word_mux_16.sv
// Selects word[idx] from the held value; idx == NWORD selects the carry bit word.
module word_mux_16
  import word_unload_257_pkg::*;
#(
  parameter int NWORD = NWORD_DEF,
  parameter int IDXW  = $clog2(NWORD + 1)
) (
  input  logic [WORD_W*NWORD:0] value_i,
  input  logic [IDXW-1:0]       idx_i,
  output logic [WORD_W-1:0]     word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NWORD; k++)
      if (idx_i == IDXW'(k)) word_o = value_i[k*WORD_W +: WORD_W];
    if (idx_i == IDXW'(NWORD)) word_o = {{(WORD_W-1){1'b0}}, value_i[WORD_W*NWORD]};
  end

endmodule

// File: rtl/word_unload_257.sv
// Holds a {carry, NWORD x 16-bit} value; supports a 1-bit right shift and a
// ready/valid word-serial unload, least significant word first.
module word_unload_257
  import word_unload_257_pkg::*;
#(
  parameter int NWORD    = NWORD_DEF,
  parameter int EMIT_TOP = 0
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      load,
  input  logic [WORD_W*NWORD-1:0]   din,
  input  logic                      top_in,
  input  logic                      rsh,
  input  logic                      start,
  output logic [WORD_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      lsb_out,
  output logic                      busy,
  output logic                      held
);

  localparam int VW   = WORD_W*NWORD + 1;
  localparam int IDXW = $clog2(NWORD + 1);
  localparam logic [IDXW-1:0] LAST = (EMIT_TOP != 0) ? IDXW'(NWORD) : IDXW'(NWORD - 1);

  state_e          state_q;
  logic [VW-1:0]   value_q;
  logic [IDXW-1:0] idx_q;
  logic            held_q;
  logic            lsb_q;
  logic [WORD_W-1:0] mux_word;

  word_mux_16 #(.NWORD(NWORD), .IDXW(IDXW)) u_mux (
    .value_i (value_q),
    .idx_i   (idx_q),
    .word_o  (mux_word)
  );

  // Outputs decode from registered state only, so reset forces them low at once.
  assign dout_valid = (state_q == ST_EMIT);
  assign dout       = dout_valid ? mux_word : '0;
  assign dout_last  = dout_valid && (idx_q == LAST);
  assign busy       = (state_q != ST_IDLE);
  assign held       = held_q;
  assign lsb_out    = lsb_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      idx_q   <= '0;
      held_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            value_q <= {top_in, din};
            held_q  <= 1'b1;
            lsb_q   <= 1'b0;
          end else if (rsh && held_q) begin
            state_q <= ST_SHIFT;
          end else if (start && held_q) begin
            state_q <= ST_EMIT;
            idx_q   <= '0;
          end
        end
        ST_SHIFT: begin
          value_q <= value_q >> 1;
          lsb_q   <= value_q[0];
          state_q <= ST_IDLE;
        end
        ST_EMIT: begin
          if (dout_ready) begin
            if (idx_q == LAST) begin
              state_q <= ST_IDLE;
              held_q  <= 1'b0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_unload_257.sv
// Randomized self-checking bench for word_unload_257 against a value-level model.
module tb_word_unload_257;
  localparam int NW = 16;

  logic clk = 0, clr_n = 0, load = 0, top_in = 0, rsh = 0;
  logic start = 0, start1 = 0, dout_ready = 0;
  logic [16*NW-1:0] din = '0;
  logic [15:0] dout0, dout1;
  logic v0, v1, l0, l1, lsb0, lsb1, b0, b1, h0, h1;

  always #5 clk = ~clk;

  word_unload_257 #(.NWORD(NW), .EMIT_TOP(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .load(load), .din(din), .top_in(top_in), .rsh(rsh),
    .start(start), .dout(dout0), .dout_valid(v0), .dout_ready(dout_ready),
    .dout_last(l0), .lsb_out(lsb0), .busy(b0), .held(h0));

  word_unload_257 #(.NWORD(NW), .EMIT_TOP(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .load(load), .din(din), .top_in(top_in), .rsh(rsh),
    .start(start1), .dout(dout1), .dout_valid(v1), .dout_ready(dout_ready),
    .dout_last(l1), .lsb_out(lsb1), .busy(b1), .held(h1));

  logic sel = 0;
  wire [15:0] c_dout  = sel ? dout1 : dout0;
  wire        c_valid = sel ? v1 : v0;
  wire        c_last  = sel ? l1 : l0;

  int n_cmp = 0, n_err = 0;
  logic [256:0] mval = '0;
  logic         mlsb = 0;
  logic [15:0]  obs_w[$];
  logic         obs_l[$];
  logic         first_valid, timeout;
  int           stab_err;

  // Reference: word k of the 257-bit value; index NW is the carry word.
  function automatic logic [15:0] mword(input logic [256:0] v, input int k);
    if (k < NW) return v[k*16 +: 16];
    return {15'b0, v[256]};
  endfunction

  function automatic logic [255:0] pattern();
    logic [255:0] d;
    for (int k = 0; k < NW; k++) d[k*16 +: 16] = 16'(k + 1);
    return d;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step(); @(negedge clk); endtask

  task automatic do_load(input logic [255:0] d, input logic t);
    din = d; top_in = t; load = 1; step(); load = 0;
    mval = {t, d}; mlsb = 0;
  endtask

  task automatic do_rsh();
    rsh = 1; step(); rsh = 0; step();
    mlsb = mval[0]; mval = mval >> 1;
  endtask

  task automatic kick(input logic which);
    if (which) start1 = 1; else start = 1;
    step(); start = 0; start1 = 0;
  endtask

  // Drives ready per mode (0 always, 1 = 1,0,0,1 repeating, 2 random) and records transfers.
  task automatic collect(input int mode);
    logic r, stalled, done;
    logic [15:0] pd;
    obs_w.delete(); obs_l.delete();
    stab_err = 0; timeout = 1; stalled = 0; pd = '0;
    first_valid = c_valid;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stalled && c_dout !== pd) stab_err++;
      case (mode)
        0: r = 1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dout_ready = r;
      stalled = c_valid && !r;
      pd = c_dout;
      done = c_valid && r && c_last;
      if (c_valid && r) begin obs_w.push_back(c_dout); obs_l.push_back(c_last); end
      step();
      if (done) begin timeout = 0; break; end
    end
    dout_ready = 0;
  endtask

  task automatic test_reset();
    clr_n = 0; step();
    n_cmp++;
    if ({dout0, v0, l0, lsb0, b0, h0} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", {dout0, v0, l0, lsb0, b0, h0});
    end
    clr_n = 1; step();
  endtask

  task automatic test_unload();
    int bad;
    do_load(pattern(), 1);
    kick(0); collect(0);
    n_cmp++; if (timeout || first_valid !== 1) begin n_err++; $display("FAIL unload_latency got valid=%b timeout=%b want 1/0", first_valid, timeout); end
    n_cmp++; if (obs_w.size() != NW) begin n_err++; $display("FAIL unload_count got %0d want %0d", obs_w.size(), NW); end
    bad = 0;
    for (int k = 0; k < obs_w.size() && k < NW; k++) begin
      n_cmp++;
      if (obs_w[k] !== 16'(k + 1) || obs_l[k] !== (k == NW - 1)) begin
        n_err++; $display("FAIL unload_word%0d got %h/%b want %h/%b", k, obs_w[k], obs_l[k], 16'(k + 1), k == NW - 1);
      end
    end
    n_cmp++; if (h0 !== 0 || v0 !== 0) begin n_err++; $display("FAIL unload_after got held=%b valid=%b want 0/0", h0, v0); end
    kick(0);
    n_cmp++; if (b0 !== 0 || v0 !== 0) begin n_err++; $display("FAIL start_unheld got busy=%b valid=%b want 0/0", b0, v0); end
  endtask

  task automatic test_stall();
    do_load(pattern(), 1);
    kick(0); collect(1);
    n_cmp++; if (timeout || obs_w.size() != NW) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_w.size(), NW); end
    for (int k = 0; k < obs_w.size() && k < NW; k++) begin
      n_cmp++;
      if (obs_w[k] !== mword(mval, k)) begin n_err++; $display("FAIL stall_word%0d got %h want %h", k, obs_w[k], mword(mval, k)); end
    end
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
  endtask

  task automatic test_rsh();
    do_load(256'h3, 1);
    rsh = 1; step(); rsh = 0;
    n_cmp++; if (b0 !== 1) begin n_err++; $display("FAIL rsh_busy got %b want 1", b0); end
    din = rnd256(); load = 1; start = 1; step(); load = 0; start = 0;
    mlsb = mval[0]; mval = mval >> 1;
    n_cmp++; if (b0 !== 0 || lsb0 !== mlsb) begin n_err++; $display("FAIL rsh_done got busy=%b lsb=%b want 0/%b", b0, lsb0, mlsb); end
    kick(0); collect(0);
    n_cmp++; if (timeout || obs_w.size() != NW) begin n_err++; $display("FAIL rsh_count got %0d want %0d", obs_w.size(), NW); end
    else begin
      n_cmp++; if (obs_w[0] !== mword(mval, 0)) begin n_err++; $display("FAIL rsh_word0 got %h want %h", obs_w[0], mword(mval, 0)); end
      n_cmp++; if (obs_w[NW-1] !== mword(mval, NW - 1)) begin n_err++; $display("FAIL rsh_word15 got %h want %h", obs_w[NW-1], mword(mval, NW - 1)); end
    end
    sel = 1; kick(1); collect(0); sel = 0;
    n_cmp++; if (timeout || obs_w.size() != NW + 1) begin n_err++; $display("FAIL rsh_top_count got %0d want %0d", obs_w.size(), NW + 1); end
    else begin
      n_cmp++; if (obs_w[NW] !== mword(mval, NW)) begin n_err++; $display("FAIL rsh_top got %h want %h", obs_w[NW], mword(mval, NW)); end
    end
  endtask

  task automatic test_emit_top();
    do_load(pattern(), 1);
    sel = 1; kick(1); collect(2); sel = 0;
    n_cmp++; if (timeout || obs_w.size() != NW + 1) begin n_err++; $display("FAIL top_count got %0d want %0d", obs_w.size(), NW + 1); end
    else begin
      for (int k = 0; k <= NW; k++) begin
        n_cmp++;
        if (obs_w[k] !== mword(mval, k) || obs_l[k] !== (k == NW)) begin
          n_err++; $display("FAIL top_word%0d got %h/%b want %h/%b", k, obs_w[k], obs_l[k], mword(mval, k), k == NW);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(pattern(), 1);
    kick(0);
    dout_ready = 1; repeat (5) step(); dout_ready = 0;
    n_cmp++; if (dout0 !== mword(mval, 5) || v0 !== 1) begin n_err++; $display("FAIL mid_word5 got %h want %h", dout0, mword(mval, 5)); end
    #2 clr_n = 0; #1;
    n_cmp++;
    if ({dout0, v0, l0, lsb0, b0, h0} !== '0) begin
      n_err++; $display("FAIL mid_reset got %h want 0", {dout0, v0, l0, lsb0, b0, h0});
    end
    step(); clr_n = 1; step();
    kick(0); step();
    n_cmp++; if (b0 !== 0 || v0 !== 0) begin n_err++; $display("FAIL mid_restart got busy=%b valid=%b want 0/0", b0, v0); end
    mval = '0; mlsb = 0;
  endtask

  task automatic test_load_start();
    logic [255:0] d;
    d = rnd256();
    din = d; top_in = 0; load = 1; start = 1; step(); load = 0; start = 0;
    mval = {1'b0, d}; mlsb = 0;
    n_cmp++; if (b0 !== 0 || h0 !== 1) begin n_err++; $display("FAIL load_start got busy=%b held=%b want 0/1", b0, h0); end
    kick(0); collect(0);
    n_cmp++; if (timeout || obs_w.size() != NW || obs_w[0] !== mword(mval, 0)) begin
      n_err++; $display("FAIL load_start_unload got n=%0d want %0d", obs_w.size(), NW);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 20; it++) begin
      do_load(rnd256(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) do_rsh();
      n_cmp++; if (lsb0 !== mlsb) begin n_err++; $display("FAIL rnd%0d_lsb got %b want %b", it, lsb0, mlsb); end
      kick(0); collect(2);
      bad = 0;
      if (timeout || obs_w.size() != NW) bad = 1;
      else for (int k = 0; k < NW; k++) if (obs_w[k] !== mword(mval, k) || obs_l[k] !== (k == NW - 1)) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rnd%0d_unload got %0d bad words (n=%0d) want 0", it, bad, obs_w.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_unload();
    test_stall();
    test_rsh();
    test_emit_top();
    test_reset_mid();
    test_load_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
